dpram_march_bist: RTL and testbench

- Built-in self-test controller that acts as the initiator on both ports of the team's 8-bit dual-port RAM.
- Runs a three-phase march over every address: background write, read-check-invert, descending dual-port read-check.
- Reports pass/fail and captures the first mismatch.
- Sits beside the RAM. Its RAM-side outputs connect to the RAM's WeA/WeB/SPM/addr/din inputs; the RAM's doutA/doutB feed back into it.

---
 rtl/dpram_march_bist.sv | 245 ++++++++++++++++++++++++
 tb/tb_dpram_march_bist.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_march_bist.sv
// dpram_march_bist: march-test BIST controller for the team's dual-port RAM.
// Three phases run over every address:
//   BG  - ascending background write of PATTERN on port A
//   RWI - ascending read on port B, write ~PATTERN on port A
//   RDD - descending read on both ports
// Each read command loads a one-entry pending register (address, expected data,
// phase, which ports to check). That entry is compared against ram_dout on the
// next rising edge. The first mismatch is captured, and the run stops on that edge.
//
// Handshake: start is a one-cycle request. It is accepted only in IDLE or DONE.
// busy stays high from the start edge until done rises. done, pass and fail_*
// hold until the next accepted start or Clr.
module dpram_march_bist #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual,
  output logic [1:0]        fail_phase,
  output logic              fail_port,
  output logic              ram_SPM,
  output logic              ram_WeA,
  output logic              ram_WeB,
  output logic [ADDR_W-1:0] ram_addrA,
  output logic [ADDR_W-1:0] ram_addrB,
  output logic [DATA_W-1:0] ram_dinA,
  output logic [DATA_W-1:0] ram_dinB,
  input  logic [DATA_W-1:0] ram_doutA,
  input  logic [DATA_W-1:0] ram_doutB,
  output logic [2:0]        dbg_state_o
);

  localparam logic [DATA_W-1:0] PAT_INV = ~PATTERN;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BG   = 3'd1,
    S_RWI  = 3'd2,
    S_RDD  = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_act_q, fail_act_d;
  logic [1:0]        fail_phase_q, fail_phase_d;
  logic              fail_port_q, fail_port_d;
  logic              we_a_q, we_a_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_a_q, din_a_d;
  logic              pend_a_q, pend_a_d;   // pending compare on port A
  logic              pend_b_q, pend_b_d;   // pending compare on port B
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_exp_q, pend_exp_d;
  logic [1:0]        pend_phase_q, pend_phase_d;

  logic idx_last;
  logic mis_a;
  logic mis_b;
  logic mismatch;

  // Compare the pending read against returned data, and detect the terminal index.
  always_comb begin
    mis_a    = pend_a_q && (ram_doutA != pend_exp_q);
    mis_b    = pend_b_q && (ram_doutB != pend_exp_q);
    mismatch = mis_a || mis_b;
    idx_last = (state_q == S_RDD) ? (idx_q == '0) : (idx_q == '1);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_exp_q   <= '0;
      fail_act_q   <= '0;
      fail_phase_q <= 2'd0;
      fail_port_q  <= 1'b0;
      we_a_q       <= 1'b0;
      addr_q       <= '0;
      din_a_q      <= '0;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      pend_addr_q  <= '0;
      pend_exp_q   <= '0;
      pend_phase_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_exp_q   <= fail_exp_d;
      fail_act_q   <= fail_act_d;
      fail_phase_q <= fail_phase_d;
      fail_port_q  <= fail_port_d;
      we_a_q       <= we_a_d;
      addr_q       <= addr_d;
      din_a_q      <= din_a_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      pend_addr_q  <= pend_addr_d;
      pend_exp_q   <= pend_exp_d;
      pend_phase_q <= pend_phase_d;
    end
  end

  // Next-state selection; a mismatch ends the run immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_BG;
      S_BG:           if (idx_last) state_d = S_RWI;
      S_RWI:          if (idx_last) state_d = S_RDD;
      S_RDD:          if (idx_last) state_d = S_CHK;
      S_CHK:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (mismatch) state_d = S_DONE;
  end

  // Next values of commands, pending entry, status and captured failure.
  always_comb begin
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_exp_d   = fail_exp_q;
    fail_act_d   = fail_act_q;
    fail_phase_d = fail_phase_q;
    fail_port_d  = fail_port_q;
    we_a_d       = 1'b0;
    addr_d       = '0;
    din_a_d      = '0;
    pend_a_d     = 1'b0;
    pend_b_d     = 1'b0;
    pend_addr_d  = '0;
    pend_exp_d   = '0;
    pend_phase_d = 2'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_exp_d   = '0;
          fail_act_d   = '0;
          fail_phase_d = 2'd0;
          fail_port_d  = 1'b0;
          idx_d        = '0;
        end
      end
      S_BG: begin
        we_a_d  = 1'b1;
        addr_d  = idx_q;
        din_a_d = PATTERN;
        idx_d   = idx_last ? '0 : idx_q + 1'b1;
      end
      S_RWI: begin
        // Mode 10: port B returns the value before this cycle's port-A write.
        we_a_d       = 1'b1;
        addr_d       = idx_q;
        din_a_d      = PAT_INV;
        pend_b_d     = 1'b1;
        pend_addr_d  = idx_q;
        pend_exp_d   = PATTERN;
        pend_phase_d = 2'd1;
        idx_d        = idx_last ? '1 : idx_q + 1'b1;
      end
      S_RDD: begin
        addr_d       = idx_q;
        pend_a_d     = 1'b1;
        pend_b_d     = 1'b1;
        pend_addr_d  = idx_q;
        pend_exp_d   = PAT_INV;
        pend_phase_d = 2'd2;
        idx_d        = idx_q - 1'b1;
      end
      S_CHK: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = 1'b1;
      end
      default: ;
    endcase
    if (mismatch) begin
      // Stop on the failing edge: no further RAM command, port A reported first.
      we_a_d       = 1'b0;
      addr_d       = '0;
      din_a_d      = '0;
      pend_a_d     = 1'b0;
      pend_b_d     = 1'b0;
      pend_addr_d  = '0;
      pend_exp_d   = '0;
      pend_phase_d = 2'd0;
      busy_d       = 1'b0;
      done_d       = 1'b1;
      pass_d       = 1'b0;
      fail_addr_d  = pend_addr_q;
      fail_exp_d   = pend_exp_q;
      fail_phase_d = pend_phase_q;
      fail_port_d  = mis_a ? 1'b0 : 1'b1;
      fail_act_d   = mis_a ? ram_doutA : ram_doutB;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_exp_q;
  assign fail_actual   = fail_act_q;
  assign fail_phase    = fail_phase_q;
  assign fail_port     = fail_port_q;
  assign ram_SPM       = 1'b0;
  assign ram_WeA       = we_a_q;
  assign ram_WeB       = 1'b0;
  assign ram_addrA     = addr_q;
  assign ram_addrB     = addr_q;
  assign ram_dinA      = din_a_q;
  assign ram_dinB      = '0;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dpram_march_bist.sv
// Bench for dpram_march_bist: a behavioural dual-port RAM beside each DUT,
// a fault injector on the read-data path, a vector table of march runs, and
// hand-written sequences for Clr mid-run, start while busy and a 4-bit build.
module tb_dpram_march_bist;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Clr   = 1'b1;
  logic start = 1'b0;

  // ---------------- default-size DUT ----------------
  logic       busy, done, pass, fail_port, ram_SPM, ram_WeA, ram_WeB;
  logic [7:0] fail_addr, fail_expected, fail_actual;
  logic [1:0] fail_phase;
  logic [7:0] ram_addrA, ram_addrB, ram_dinA, ram_dinB;
  logic [7:0] dut_doutA, dut_doutB;
  logic [2:0] dbg_state;

  dpram_march_bist dut (
    .Clk(Clk), .Clr(Clr), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
    .fail_phase(fail_phase), .fail_port(fail_port),
    .ram_SPM(ram_SPM), .ram_WeA(ram_WeA), .ram_WeB(ram_WeB),
    .ram_addrA(ram_addrA), .ram_addrB(ram_addrB),
    .ram_dinA(ram_dinA), .ram_dinB(ram_dinB),
    .ram_doutA(dut_doutA), .ram_doutB(dut_doutB),
    .dbg_state_o(dbg_state)
  );

  // RAM model: commands sampled on the falling edge; mode 01 zeroes mem[addrA].
  logic [7:0] mem [256];
  logic [7:0] m_doutA, m_doutB;
  always @(negedge Clk) begin
    m_doutA <= mem[ram_addrA];
    m_doutB <= mem[ram_addrB];
    if (ram_WeA) mem[ram_addrA] <= ram_dinA;
    else if (ram_WeB) mem[ram_addrA] <= 8'h00;
  end

  // Fault injector: replaces read data sampled at edge inj_edge (edge 0 = start edge).
  int         edge_n = 0;
  int         base = 0;
  logic       inj_a = 1'b0, inj_b = 1'b0;
  int         inj_edge = 0;
  logic [7:0] inj_val = 8'h00;
  logic       inj_now;
  always @(posedge Clk) edge_n <= edge_n + 1;
  assign inj_now   = ((edge_n - base) == (inj_edge - 1));
  assign dut_doutA = (inj_a && inj_now) ? inj_val : m_doutA;
  assign dut_doutB = (inj_b && inj_now) ? inj_val : m_doutB;

  // ---------------- small DUT: ADDR_W=4, PATTERN=8'h0F ----------------
  logic       start_s = 1'b0;
  logic       s_busy, s_done, s_pass, s_fail_port, s_SPM, s_WeA, s_WeB;
  logic [3:0] s_fail_addr, s_addrA, s_addrB;
  logic [7:0] s_fail_exp, s_fail_act, s_dinA, s_dinB;
  logic [1:0] s_fail_phase;
  logic [7:0] s_doutA, s_doutB;
  logic [2:0] s_dbg;

  dpram_march_bist #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'h0F)) dut_s (
    .Clk(Clk), .Clr(Clr), .start(start_s),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .fail_addr(s_fail_addr), .fail_expected(s_fail_exp), .fail_actual(s_fail_act),
    .fail_phase(s_fail_phase), .fail_port(s_fail_port),
    .ram_SPM(s_SPM), .ram_WeA(s_WeA), .ram_WeB(s_WeB),
    .ram_addrA(s_addrA), .ram_addrB(s_addrB),
    .ram_dinA(s_dinA), .ram_dinB(s_dinB),
    .ram_doutA(s_doutA), .ram_doutB(s_doutB),
    .dbg_state_o(s_dbg)
  );

  logic [7:0] s_mem [16];
  always @(negedge Clk) begin
    s_doutA <= s_mem[s_addrA];
    s_doutB <= s_mem[s_addrB];
    if (s_WeA) s_mem[s_addrA] <= s_dinA;
    else if (s_WeB) s_mem[s_addrA] <= 8'h00;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {31'd0, busy, done, pass, fail_addr, fail_expected, fail_actual, fail_phase,
            fail_port, ram_SPM, ram_WeA, ram_WeB, ram_addrA, ram_addrB, ram_dinA, ram_dinB};
  endfunction

  function automatic int mem_bad(input logic [7:0] want);
    int n = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== want) n++;
    return n;
  endfunction

  // One march run on the default DUT. Start pulses at edges p1/p2 are extra requests
  // issued while busy. Returns the done edge (-1 on timeout) and health flags.
  task automatic run_march(input logic ia, input logic ib, input int ie, input logic [7:0] iv,
                           input int p1, input int p2,
                           output int done_edge, output logic busy_ok, output logic post_ok);
    inj_a = ia; inj_b = ib; inj_edge = ie; inj_val = iv;
    done_edge = -1; busy_ok = 1'b1; post_ok = 1'b1;
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;   // edge 0
    base = edge_n;
    chk("start_clear", {done, pass, busy, fail_addr, fail_expected, fail_actual, fail_phase, fail_port},
        {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0});
    for (int k = 1; k <= 1000; k++) begin
      if (k == p1 || k == p2) start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
      if (ram_WeB || ram_SPM || ram_dinB != 8'h00) post_ok = 1'b0;
      if (done) begin
        done_edge = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (busy) busy_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ram_WeA || ram_WeB || !done || busy) post_ok = 1'b0;
      @(posedge Clk); #1;
    end
    inj_a = 1'b0; inj_b = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ia;
    logic       ib;
    int         ie;
    logic [7:0] iv;
    int         exp_edge;
    logic       exp_pass;
    logic [7:0] exp_addr;
    logic [7:0] exp_expd;
    logic [7:0] exp_act;
    logic [1:0] exp_phase;
    logic       exp_port;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         de;
    logic       bok, pok;
    int         sde;

    // healthy run
    vecs[0] = '{1'b0, 1'b0, 0,   8'h00, 769, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    // RWI address 3C: command edge 317, compare edge 318, port B
    vecs[1] = '{1'b0, 1'b1, 318, 8'h54, 318, 1'b0, 8'h3C, 8'h55, 8'h54, 2'd1, 1'b1};
    // RDD address 00: last command edge 768, compare edge 769, port A
    vecs[2] = '{1'b1, 1'b0, 769, 8'hAB, 769, 1'b0, 8'h00, 8'hAA, 8'hAB, 2'd2, 1'b0};
    // first RWI compare (address 00) at edge 258
    vecs[3] = '{1'b0, 1'b1, 258, 8'h56, 258, 1'b0, 8'h00, 8'h55, 8'h56, 2'd1, 1'b1};
    // first RDD compare (address FF) at edge 514, port B
    vecs[4] = '{1'b0, 1'b1, 514, 8'h2A, 514, 1'b0, 8'hFF, 8'hAA, 8'h2A, 2'd2, 1'b1};
    // RDD address 80, both ports wrong: port A reported
    vecs[5] = '{1'b1, 1'b1, 641, 8'h00, 641, 1'b0, 8'h80, 8'hAA, 8'h00, 2'd2, 1'b0};

    // reset state
    Clr = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", all_outs(), 96'd0);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    Clr = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_march(vecs[v].ia, vecs[v].ib, vecs[v].ie, vecs[v].iv, -1, -1, de, bok, pok);
      chk($sformatf("v%0d_done_edge", v), de, vecs[v].exp_edge);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].exp_addr);
      chk($sformatf("v%0d_fail_expected", v), fail_expected, vecs[v].exp_expd);
      chk($sformatf("v%0d_fail_actual", v), fail_actual, vecs[v].exp_act);
      chk($sformatf("v%0d_fail_phase", v), fail_phase, vecs[v].exp_phase);
      chk($sformatf("v%0d_fail_port", v), fail_port, vecs[v].exp_port);
      chk($sformatf("v%0d_busy_span", v), bok, 1'b1);
      chk($sformatf("v%0d_quiet_after_done", v), pok, 1'b1);
      if (v == 0) chk("v0_ram_not_AA", mem_bad(8'hAA), 0);
    end

    // start pulses at edges 5 and 400 while busy are ignored
    run_march(1'b0, 1'b0, 0, 8'h00, 5, 400, de, bok, pok);
    chk("busy_start_done_edge", de, 769);
    chk("busy_start_pass", pass, 1'b1);
    chk("busy_start_busy_span", bok, 1'b1);

    // Clr asserted at edge 300 (mid-RWI)
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;   // edge 0
    for (int k = 1; k < 300; k++) @(posedge Clk);
    #1 Clr = 1'b1;
    @(posedge Clk); #1;                // edge 300
    chk("clr_outputs", all_outs(), 96'd0);
    chk("clr_state", {29'd0, dbg_state}, 32'd0);
    Clr = 1'b0;
    @(posedge Clk); #1;
    chk("clr_stays_idle", {ram_WeA, busy, dbg_state}, 5'd0);
    run_march(1'b0, 1'b0, 0, 8'h00, -1, -1, de, bok, pok);
    chk("after_clr_done_edge", de, 769);
    chk("after_clr_pass", pass, 1'b1);
    chk("after_clr_ram_not_AA", mem_bad(8'hAA), 0);

    // 4-bit address build with PATTERN 0F
    sde = -1;
    @(posedge Clk); #1 start_s = 1'b1;
    @(posedge Clk); #1 start_s = 1'b0;  // edge 0
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk); #1;
      if (s_done) begin
        sde = k;
        break;
      end
    end
    chk("small_done_edge", sde, 49);
    chk("small_pass", s_pass, 1'b1);
    begin
      int n = 0;
      for (int a = 0; a < 16; a++) if (s_mem[a] !== 8'hF0) n++;
      chk("small_ram_not_F0", n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
